// File: rtl/utils_pkg.sv
// Shared CSR operation type, counter/HPM address map and helpers.
// Used by the core CSR unit and the csr_hpm counter bank.
package utils_pkg;

    typedef enum logic [2:0] {
        CSR_NONE,
        CSR_RW,
        CSR_RS,
        CSR_RC,
        CSR_RWI,
        CSR_RSI,
        CSR_RCI
    } csr_t;

    localparam logic [11:0] RV_CSR_MCOUNTINHIBIT       = 12'h320;
    localparam logic [11:0] RV_CSR_MHPMEVENT_BASE      = 12'h320;
    localparam logic [11:0] RV_CSR_MHPMCOUNTER_BASE    = 12'hB00;
    localparam logic [11:0] RV_CSR_MHPMCOUNTER_H_BASE  = 12'hB80;
    localparam logic [11:0] RV_CSR_HPM_USR_BASE        = 12'hC00;
    localparam logic [11:0] RV_CSR_HPM_USR_H_BASE      = 12'hC80;
    localparam logic [11:0] RV_CSR_MCOUNTEROVF         = 12'h7C0;
    localparam logic [11:0] RV_CSR_OVF_MASK            = 12'h7C1;

    function automatic logic [31:0] csr_wval(
        input csr_t        op,
        input logic [31:0] old,
        input logic [31:0] opnd
    );
        logic [31:0] v;
        case (op)
            CSR_RW, CSR_RWI: v = opnd;
            CSR_RS, CSR_RSI: v = old | opnd;
            CSR_RC, CSR_RCI: v = old & ~opnd;
            default:         v = old;
        endcase
        return v;
    endfunction

    // Implemented counter bits: all indices below n except time (bit 1).
    function automatic logic [31:0] cnt_mask(input int n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n && i != 1) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/hpm_counter.sv
// One machine counter: write to either half beats the increment,
// overflow pulses when an increment wraps all-ones to zero.
module hpm_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic [31:0]          wdata_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 ovf_o
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) cnt_d[31:0] = wdata_i;
            if (wr_hi_i) cnt_d[CNT_WIDTH-1:32] = wdata_i[CNT_WIDTH-33:0];
        end else if (inc_i) begin
            cnt_d = cnt_q + ONE;
            ovf_o = &cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_hpm.sv
// Machine counter / HPM CSR bank with sticky overflow flags.
// Optional overflow interrupt and mask CSR under HPM_OVF_IRQ_EN.
module csr_hpm
    import utils_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_EVENTS = 8,
    parameter int EVT_SEL_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic [11:0]           csr_addr_i,
    input  csr_t                  csr_op_i,
    input  logic                  rs1_is_x0_i,
    input  logic [31:0]           rs1_data_i,
    input  logic [31:0]           imm_i,
    input  logic                  instr_ret_i,
    input  logic [NUM_EVENTS-1:0] evt_i,
    output logic [31:0]           csr_rd_o,
    output logic                  csr_hit_o,
    output logic                  csr_illegal_o,
    output logic                  ovf_irq_o
);

    localparam int          NCNT     = 3 + NUM_HPM;
    localparam logic [31:0] CNT_MASK = cnt_mask(NCNT);

    logic [CNT_WIDTH-1:0]               cnt [NCNT];
    logic [NCNT-1:0]                    ovf_p;
    logic [31:0]                        ovf_set;
    logic [31:0]                        inhibit_d, inhibit_q;
    logic [31:0]                        ovf_d, ovf_q;
    logic [NCNT-1:0][EVT_SEL_W-1:0]     sel_d, sel_q;
    logic [4:0]                         idx;
    logic                               hi;
    logic                               is_mcnt, is_ucnt, is_evt, is_ovf;
    logic                               is_mask;
    logic [31:0]                        mask_rd;
    logic                               wr_eff, we;
    logic [31:0]                        opnd, wval;

    function automatic logic evt_sel(
        input logic [EVT_SEL_W-1:0]  s,
        input logic [NUM_EVENTS-1:0] e
    );
        logic r;
        r = 1'b0;
        for (int k = 1; k <= NUM_EVENTS; k++) begin
            if (int'(s) == k) r = e[k-1];
        end
        return r;
    endfunction

`ifdef HPM_OVF_IRQ_EN
    logic [31:0] mask_d, mask_q;
    logic        irq_d, irq_q;

    assign is_mask = (csr_addr_i == RV_CSR_OVF_MASK);
    assign mask_rd = mask_q;

    always_comb begin
        mask_d = mask_q;
        if (we && is_mask) mask_d = wval & CNT_MASK;
        irq_d = |(ovf_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign ovf_irq_o = irq_q;
`else
    assign is_mask   = 1'b0;
    assign mask_rd   = '0;
    assign ovf_irq_o = 1'b0;
`endif

    always_comb begin
        idx     = csr_addr_i[4:0];
        hi      = csr_addr_i[7];
        is_mcnt = (csr_addr_i[11:8] == RV_CSR_MHPMCOUNTER_BASE[11:8])
                  && (csr_addr_i[6:5] == 2'b00);
        is_ucnt = (csr_addr_i[11:8] == RV_CSR_HPM_USR_BASE[11:8])
                  && (csr_addr_i[6:5] == 2'b00);
        is_evt  = (csr_addr_i[11:5] == RV_CSR_MHPMEVENT_BASE[11:5]);
        is_ovf  = (csr_addr_i == RV_CSR_MCOUNTEROVF);
        csr_hit_o = is_mcnt | is_ucnt | is_evt | is_ovf | is_mask;

        csr_rd_o = '0;
        if (is_mcnt || is_ucnt) begin
            for (int i = 0; i < NCNT; i++) begin
                if (idx == 5'(i))
                    csr_rd_o = hi ? 32'(cnt[i][CNT_WIDTH-1:32]) : cnt[i][31:0];
            end
        end else if (is_evt) begin
            if (idx == 5'd0) csr_rd_o = inhibit_q;
            for (int i = 3; i < NCNT; i++) begin
                if (idx == 5'(i)) csr_rd_o = 32'(sel_q[i]);
            end
        end else if (is_ovf) begin
            csr_rd_o = ovf_q;
        end else if (is_mask) begin
            csr_rd_o = mask_rd;
        end

        case (csr_op_i)
            CSR_RW, CSR_RWI:                  wr_eff = 1'b1;
            CSR_RS, CSR_RC, CSR_RSI, CSR_RCI: wr_eff = ~rs1_is_x0_i;
            default:                          wr_eff = 1'b0;
        endcase
        opnd = (csr_op_i inside {CSR_RWI, CSR_RSI, CSR_RCI}) ? imm_i : rs1_data_i;
        wval = csr_wval(csr_op_i, csr_rd_o, opnd);
        csr_illegal_o = is_ucnt & wr_eff;
        we = wr_eff & ~stall_i & csr_hit_o & ~is_ucnt;
    end

    always_comb begin
        inhibit_d = inhibit_q;
        if (we && is_evt && idx == 5'd0) inhibit_d = wval & CNT_MASK;
        sel_d = sel_q;
        for (int i = 3; i < NCNT; i++) begin
            if (we && is_evt && idx == 5'(i)) sel_d[i] = wval[EVT_SEL_W-1:0];
        end
        ovf_set = '0;
        ovf_set[NCNT-1:0] = ovf_p;
        // A same-cycle overflow outranks the W1C clear of its flag.
        ovf_d = ovf_q;
        if (we && is_ovf) ovf_d = ovf_q & ~opnd;
        ovf_d = (ovf_d | ovf_set) & CNT_MASK;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inhibit_q <= '0;
            ovf_q     <= '0;
            sel_q     <= '0;
        end else begin
            inhibit_q <= inhibit_d;
            ovf_q     <= ovf_d;
            sel_q     <= sel_d;
        end
    end

    for (genvar i = 0; i < NCNT; i++) begin : g_cnt
        if (i == 1) begin : g_time
            assign cnt[i]   = '0;
            assign ovf_p[i] = 1'b0;
        end else begin : g_hpm
            logic ev, inc, wr;
            if (i == 0) begin : g_cyc
                assign ev = 1'b1;
            end else if (i == 2) begin : g_ret
                assign ev = instr_ret_i;
            end else begin : g_evt
                assign ev = evt_sel(sel_q[i], evt_i);
            end
            assign inc = ev & ~inhibit_q[i];
            assign wr  = we & is_mcnt & (idx == 5'(i));
            hpm_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
                .clk     (clk),
                .rst     (rst),
                .inc_i   (inc),
                .wr_lo_i (wr & ~hi),
                .wr_hi_i (wr & hi),
                .wdata_i (wval),
                .cnt_o   (cnt[i]),
                .ovf_o   (ovf_p[i])
            );
        end
    end

endmodule
